// File: rtl/cic3_row_pkg.sv
// cic3_row_pkg: shared types, default sizes and counter-width helper for the CIC3 row readout
package cic3_row_pkg;
    typedef enum logic [1:0] {IDLE, RST_HOLD, SETTLE, RUN} cic3_row_state_t;
    localparam int DEF_NUM_FILTERS = 24;
    localparam int DEF_WORD_W = 8;
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/cic3_row_fifo.sv
// cic3_row_fifo: 2-entry snapshot queue; push while full is taken when a pop happens in the same cycle
module cic3_row_fifo #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         clr,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic wr_q, wr_d, rd_q, rd_d, do_push, do_pop;
    logic [1:0] cnt_q, cnt_d;
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d = clr ? 1'b0 : wr_q ^ do_push;
        rd_d = clr ? 1'b0 : rd_q ^ do_pop;
        cnt_d = clr ? 2'd0 : cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q <= 1'b0;
            rd_q <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
    assign dout = mem_q[rd_q];
    assign full = cnt_q == 2'd2;
    assign empty = cnt_q == 2'd0;
    assign count = cnt_q;
endmodule

// File: rtl/cic3_row_readout_ctrl.sv
// cic3_row_readout_ctrl: row reset/settle sequencer that queues row snapshots and streams them as LSB-first beats
module cic3_row_readout_ctrl
    import cic3_row_pkg::*;
#(
    parameter int NUM_FILTERS = DEF_NUM_FILTERS,
    parameter int WORD_W = DEF_WORD_W,
    parameter int RST_CYCLES = 16,
    parameter int SETTLE_SAMPLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sample_strobe,
    input  logic [NUM_FILTERS-1:0] row_out,
    output logic                   row_reset_n,
    output logic [WORD_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   rd_last,
    input  logic                   rd_ready,
    output logic                   overflow,
    input  logic                   clr_overflow,
    output logic                   busy
);
    localparam int NBEATS = NUM_FILTERS / WORD_W;
    localparam int BW = cnt_w(NBEATS);
    localparam int CNT_W = cnt_w(RST_CYCLES > SETTLE_SAMPLES ? RST_CYCLES : SETTLE_SAMPLES);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_SAMPLES - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(NBEATS - 1);
    cic3_row_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BW-1:0] beat_q, beat_d;
    logic ovf_q, ovf_d, rrn_q, rrn_d;
    logic flush, push_req, hs, last, pop, full, empty;
    logic [1:0] count;
    logic [NUM_FILTERS-1:0] head;
    cic3_row_fifo #(.W(NUM_FILTERS)) u_fifo (
        .clk(clk), .reset(reset), .push(push_req), .pop(pop), .clr(flush),
        .din(row_out), .dout(head), .full(full), .empty(empty), .count(count)
    );
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE: if (enable) begin
                state_d = RST_HOLD;
                cnt_d = '0;
            end
            RST_HOLD: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == RST_LAST) begin
                    state_d = SETTLE;
                    cnt_d = '0;
                end
            end
            SETTLE: if (sample_strobe) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == SET_LAST) begin
                    state_d = RUN;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase
        // dropping enable abandons everything, including a half-read snapshot
        flush = state_q != IDLE && !enable;
        if (flush) state_d = IDLE;
        push_req = state_q == RUN && enable && sample_strobe;
        rd_valid = count != 2'd0;
        last = beat_q == BEAT_LAST;
        hs = rd_valid && rd_ready && !flush;
        pop = hs && last;
        beat_d = flush ? '0 : hs ? (last ? '0 : beat_q + BW'(1)) : beat_q;
        ovf_d = (push_req && full && !pop) ? 1'b1 : clr_overflow ? 1'b0 : ovf_q;
        rrn_d = state_d == SETTLE || state_d == RUN;
        rd_data = rd_valid ? head[beat_q*WORD_W +: WORD_W] : '0;
        rd_last = rd_valid && last;
        busy = state_q != IDLE || !empty;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            beat_q <= '0;
            ovf_q <= 1'b0;
            rrn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            beat_q <= beat_d;
            ovf_q <= ovf_d;
            rrn_q <= rrn_d;
        end
    end
    assign row_reset_n = rrn_q;
    assign overflow = ovf_q;
endmodule
